// File: rtl/traffic_pkg.sv
// Shared constants and FSM state type for the traffic-light display path.
package traffic_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
  localparam logic [3:0] BCD_NINE       = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } b2b_state_e;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic logic [31:0] dec_max(input int unsigned digits);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single BCD digit pre-shift adjust: digits of 5 or more get +3.
module bcd_add3
  import traffic_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_ADJ_THRESH) begin
      digit_out = digit_in + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter, one input bit per clock.
// Build option: define BIN2BCD_SAT_EN to saturate bcd_out to all nines on overflow.
module bin2bcd_seq
  import traffic_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  ovf
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W);
  localparam logic [31:0] DEC_MAX = dec_max(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
`ifdef BIN2BCD_SAT_EN
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};
`endif

  b2b_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   scratch_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_pend_d = ovf_pend_q;
    bcd_out_d  = bcd_out_q;
    ovf_d      = ovf_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d    = bin_in;
          scratch_d  = '0;
          ovf_pend_d = (32'(bin_in) > DEC_MAX);
          cnt_d      = CNT_LAST;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Top-digit carry falls off the end, leaving bin_in mod 10^DIGITS.
        scratch_d = {scratch_adj[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          // Results are registered on entry to DONE so they are already
          // visible during the out_valid cycle.
`ifdef BIN2BCD_SAT_EN
          bcd_out_d = ovf_pend_q ? ALL_NINES : scratch_d;
`else
          bcd_out_d = scratch_d;
`endif
          ovf_d = ovf_pend_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_pend_q <= 1'b0;
      bcd_out_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_out_q  <= bcd_out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bcd_out = bcd_out_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq (BIN_W=14, DIGITS=4); honours BIN2BCD_SAT_EN.
module tb_bin2bcd_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] bin_in;
  logic [15:0] bcd_out;
  logic        out_valid;
  logic        ovf;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int unsigned due;
    int unsigned val;
  } exp_t;

  exp_t        sb[$];
  int unsigned ov_cyc_q[$];
  int unsigned cyc = 0;
  int unsigned ov_cnt = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int unsigned v);
    int unsigned m;
    logic [15:0] r;
    m = v % 10000;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
`ifdef BIN2BCD_SAT_EN
    if (v > 9999) r = 16'h9999;
`endif
    return r;
  endfunction

  // Monitor: sample away from the active edge.
  always @(negedge sys_clk) begin
    exp_t e;
    if (out_valid) begin
      ov_cnt++;
      ov_cyc_q.push_back(cyc);
      if (sb.size() == 0) begin
        check_eq("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq($sformatf("bcd_out(%0d)", e.val), 32'(bcd_out), 32'(e.bcd));
        check_eq($sformatf("ovf(%0d)", e.val), 32'(ovf), 32'(e.ovf));
        check_eq($sformatf("latency(%0d)", e.val), cyc, e.due);
      end
    end
    if (sys_rst_n && in_valid && in_ready) begin
      e.val = 32'(bin_in);
      e.bcd = model_bcd(32'(bin_in));
      e.ovf = (32'(bin_in) > 9999);
      e.due = cyc + 15;
      sb.push_back(e);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [13:0] v);
    in_valid = 1'b1;
    bin_in   = v;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 100) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  int unsigned ov_before;

  initial begin
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    bin_in    = '0;
    tick(3);
    check_eq("rst_bcd_out", 32'(bcd_out), 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    sys_rst_n = 1'b1;
    tick(2);

    // Zero, normal and boundary values
    send(14'd0);
    wait_drain("drain_0");
    send(14'd59);
    wait_drain("drain_59");
    check_eq("hold_59", 32'(bcd_out), 32'h0059);
    send(14'd9999);
    wait_drain("drain_9999");
    tick(3);
    check_eq("hold_9999", 32'(bcd_out), 32'h9999);
    check_eq("hold_ovf_9999", 32'(ovf), 32'd0);

    send(14'd12345);
    wait_drain("drain_12345");
    check_eq("ovf_12345", 32'(ovf), 32'd1);
`ifdef BIN2BCD_SAT_EN
    check_eq("sat_12345", 32'(bcd_out), 32'h9999);
`else
    check_eq("wrap_12345", 32'(bcd_out), 32'h2345);
`endif

    // Busy input is ignored, in_ready low for 15 cycles after accept
    ov_before = ov_cnt;
    send(14'd42);
    for (int k = 1; k <= 15; k++) begin
      check_eq($sformatf("busy_in_ready_%0d", k), 32'(in_ready), 32'd0);
      if (k == 5) begin
        in_valid = 1'b1;
        bin_in   = 14'd77;
      end else begin
        in_valid = 1'b0;
      end
      tick(1);
    end
    check_eq("ready_after_done", 32'(in_ready), 32'd1);
    wait_drain("drain_42");
    check_eq("pulses_42", ov_cnt - ov_before, 32'd1);
    check_eq("bcd_42", 32'(bcd_out), 32'h0042);

    // Held in_valid: back-to-back conversions 16 cycles apart
    ov_cyc_q.delete();
    in_valid = 1'b1;
    bin_in   = 14'd1234;
    tick(48);
    in_valid = 1'b0;
    wait_drain("drain_1234");
    check_eq("pulses_1234", 32'(ov_cyc_q.size()), 32'd3);
    for (int i = 1; i < ov_cyc_q.size(); i++) begin
      check_eq($sformatf("spacing_1234_%0d", i), ov_cyc_q[i] - ov_cyc_q[i-1], 32'd16);
    end

    // Reset mid-conversion
    send(14'd9999);
    wait_drain("drain_9999b");
    send(14'd7);
    tick(5);
    sys_rst_n = 1'b0;
    sb.delete();
    tick(1);
    check_eq("midrst_bcd_out", 32'(bcd_out), 32'h0);
    check_eq("midrst_ovf", 32'(ovf), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    sys_rst_n = 1'b1;
    ov_before = ov_cnt;
    tick(30);
    check_eq("midrst_no_pulse", ov_cnt - ov_before, 32'd0);

    // Random values across the whole input range
    for (int i = 0; i < 8; i++) begin
      send(14'($urandom_range(16383, 0)));
      wait_drain($sformatf("drain_rand_%0d", i));
    end

    tick(2);
    check_eq("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
